// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, register-file geometry and requester IDs for the writeback arbiter.
package regfile_pkg;

    localparam int XLEN       = 64;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int NUM_REQ    = 3;

    localparam int REQ_ALU    = 0;
    localparam int REQ_LSU    = 1;
    localparam int REQ_MULDIV = 2;

    function automatic logic [NUM_REGS-1:0] reg_mask(input logic [REG_ADDR_W-1:0] r);
        return NUM_REGS'(1) << r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant over valid requests; pointer moves past the winner.
module rr_arbiter #(
    parameter int NUM_REQ = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] valid,
    output logic [NUM_REQ-1:0] grant
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] nxt;
    logic [PW-1:0] idx;
    logic          found;

    // search starts at ptr and wraps; first valid requester wins
    always_comb begin
        grant = '0;
        nxt   = ptr;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = PW'((int'(ptr) + k) % NUM_REQ);
            if (!found && valid[idx]) begin
                grant[idx] = 1'b1;
                nxt        = PW'((int'(idx) + 1) % NUM_REQ);
                found      = 1'b1;
            end
        end
        if (rst)
            grant = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= '0;
        else if (found)
            ptr <= nxt;
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: arbitrates writebacks into one register-file write port.
// Define REGFILE_SCOREBOARD_EN to add the per-register pending-write scoreboard.
module regfile_wb_arbiter #(
    parameter int XLEN    = regfile_pkg::XLEN,
    parameter int NUM_REQ = regfile_pkg::NUM_REQ
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [NUM_REQ-1:0]                       req_valid,
    input  logic [NUM_REQ*regfile_pkg::REG_ADDR_W-1:0] req_rd,
    input  logic [NUM_REQ*XLEN-1:0]                  req_data,
    output logic [NUM_REQ-1:0]                       req_ready,
    output logic                                     RegWrite,
    output logic [regfile_pkg::REG_ADDR_W-1:0]       WriteReg,
    output logic [XLEN-1:0]                          WriteData,
    input  logic                                     alloc_valid,
    input  logic [regfile_pkg::REG_ADDR_W-1:0]       alloc_rd,
    input  logic [regfile_pkg::REG_ADDR_W-1:0]       ReadReg1,
    input  logic [regfile_pkg::REG_ADDR_W-1:0]       ReadReg2,
    output logic                                     rs1_busy,
    output logic                                     rs2_busy
);

    import regfile_pkg::*;

    logic [NUM_REQ-1:0]    grant;
    logic [REG_ADDR_W-1:0] sel_rd;
    logic [XLEN-1:0]       sel_data;
    logic                  xfer;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk   (clk),
        .rst   (rst),
        .valid (req_valid),
        .grant (grant)
    );

    assign req_ready = grant;
    assign xfer      = |grant;

    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_rd   = req_rd[i*REG_ADDR_W +: REG_ADDR_W];
                sel_data = req_data[i*XLEN +: XLEN];
            end
        end
    end

    // x0 writes are accepted but never raise RegWrite
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RegWrite  <= 1'b0;
            WriteReg  <= '0;
            WriteData <= '0;
        end else begin
            RegWrite <= xfer && (sel_rd != '0);
            if (xfer) begin
                WriteReg  <= sel_rd;
                WriteData <= sel_data;
            end
        end
    end

`ifdef REGFILE_SCOREBOARD_EN
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;

    assign set_mask = (alloc_valid && alloc_rd != '0) ? reg_mask(alloc_rd) : '0;
    assign clr_mask = RegWrite ? reg_mask(WriteReg) : '0;

    // set wins over clear so a re-issue on the clearing edge stays pending
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            busy <= '0;
        else
            busy <= ((busy & ~clr_mask) | set_mask) & ~NUM_REGS'(1);
    end

    assign rs1_busy = busy[ReadReg1];
    assign rs2_busy = busy[ReadReg2];
`else
    logic unused_alloc;

    assign unused_alloc = ^{alloc_valid, alloc_rd, ReadReg1, ReadReg2};
    assign rs1_busy     = 1'b0;
    assign rs2_busy     = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed checks of arbitration, write port, x0 drop, scoreboard and reset.
module tb_regfile_wb_arbiter;

    import regfile_pkg::*;

`ifdef REGFILE_SCOREBOARD_EN
    localparam logic SB = 1'b1;
`else
    localparam logic SB = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [2:0]            req_valid = '0;
    logic [14:0]           req_rd = '0;
    logic [191:0]          req_data = '0;
    logic [2:0]            req_ready;
    logic                  RegWrite;
    logic [4:0]            WriteReg;
    logic [63:0]           WriteData;
    logic                  alloc_valid = 1'b0;
    logic [4:0]            alloc_rd = '0;
    logic [4:0]            ReadReg1 = '0;
    logic [4:0]            ReadReg2 = '0;
    logic                  rs1_busy;
    logic                  rs2_busy;

    int passed = 0;
    int total  = 0;

    regfile_wb_arbiter #(.XLEN(64), .NUM_REQ(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_rd      (req_rd),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .RegWrite    (RegWrite),
        .WriteReg    (WriteReg),
        .WriteData   (WriteData),
        .alloc_valid (alloc_valid),
        .alloc_rd    (alloc_rd),
        .ReadReg1    (ReadReg1),
        .ReadReg2    (ReadReg2),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [4:0] rd, input logic [63:0] data);
        req_rd[i*5 +: 5]    = rd;
        req_data[i*64 +: 64] = data;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // reset state, even with every requester valid
        req_valid = 3'b111;
        #1;
        chk("rst_ready", 64'(req_ready), 64'd0);
        tick();
        chk("rst_regwrite", 64'(RegWrite), 64'd0);
        chk("rst_writereg", 64'(WriteReg), 64'd0);
        chk("rst_writedata", WriteData, 64'd0);
        chk("rst_rs1_busy", 64'(rs1_busy), 64'd0);
        chk("rst_rs2_busy", 64'(rs2_busy), 64'd0);
        rst = 1'b0;

        // single request from the ALU
        req_valid = 3'b001;
        set_req(REQ_ALU, 5'd5, 64'hA5);
        #1;
        chk("single_ready", 64'(req_ready), 64'b001);
        tick();
        req_valid = 3'b000;
        chk("single_regwrite", 64'(RegWrite), 64'd1);
        chk("single_writereg", 64'(WriteReg), 64'd5);
        chk("single_writedata", WriteData, 64'hA5);
        #1;
        chk("idle_ready", 64'(req_ready), 64'd0);
        tick();
        chk("idle_regwrite", 64'(RegWrite), 64'd0);
        chk("idle_hold_reg", 64'(WriteReg), 64'd5);
        chk("idle_hold_data", WriteData, 64'hA5);

        // all requesters valid for six cycles from reset
        do_reset();
        set_req(REQ_ALU, 5'd1, 64'h10);
        set_req(REQ_LSU, 5'd2, 64'h20);
        set_req(REQ_MULDIV, 5'd3, 64'h30);
        req_valid = 3'b111;
        #1;
        chk("rr0_ready", 64'(req_ready), 64'b001);
        tick();
        chk("rr1_ready", 64'(req_ready), 64'b010);
        chk("rr1_regwrite", 64'(RegWrite), 64'd1);
        chk("rr1_writereg", 64'(WriteReg), 64'd1);
        tick();
        chk("rr2_ready", 64'(req_ready), 64'b100);
        chk("rr2_writedata", WriteData, 64'h20);
        tick();
        chk("rr3_ready", 64'(req_ready), 64'b001);
        chk("rr3_writereg", 64'(WriteReg), 64'd3);
        tick();
        chk("rr4_ready", 64'(req_ready), 64'b010);
        chk("rr4_writedata", WriteData, 64'h10);
        tick();
        chk("rr5_ready", 64'(req_ready), 64'b100);
        chk("rr5_regwrite", 64'(RegWrite), 64'd1);
        tick();
        req_valid = 3'b000;
        chk("rr6_regwrite", 64'(RegWrite), 64'd1);
        chk("rr6_writereg", 64'(WriteReg), 64'd3);
        chk("rr6_writedata", WriteData, 64'h30);
        tick();
        chk("rr7_regwrite", 64'(RegWrite), 64'd0);

        // scoreboard: alloc x7, write x7 back, re-alloc on the clearing edge
        do_reset();
        alloc_valid = 1'b1;
        alloc_rd    = 5'd7;
        ReadReg1    = 5'd7;
        ReadReg2    = 5'd7;
        #1;
        chk("sb_c0_rs1", 64'(rs1_busy), 64'd0);
        tick();
        alloc_valid = 1'b0;
        chk("sb_c1_rs1", 64'(rs1_busy), 64'(SB));
        chk("sb_c1_rs2", 64'(rs2_busy), 64'(SB));
        tick();
        tick();
        req_valid = 3'b100;
        set_req(REQ_MULDIV, 5'd7, 64'h77);
        #1;
        chk("sb_c3_ready", 64'(req_ready), 64'b100);
        tick();
        req_valid = 3'b000;
        chk("sb_c4_regwrite", 64'(RegWrite), 64'd1);
        chk("sb_c4_writereg", 64'(WriteReg), 64'd7);
        chk("sb_c4_rs1", 64'(rs1_busy), 64'(SB));
        tick();
        chk("sb_c5_rs1", 64'(rs1_busy), 64'd0);
        alloc_valid = 1'b1;
        tick();
        alloc_valid = 1'b0;
        chk("sb_c6_rs1", 64'(rs1_busy), 64'(SB));
        req_valid = 3'b100;
        tick();
        req_valid   = 3'b000;
        alloc_valid = 1'b1;
        chk("sb_c7_regwrite", 64'(RegWrite), 64'd1);
        tick();
        alloc_valid = 1'b0;
        chk("sb_setclr_rs2", 64'(rs2_busy), 64'(SB));
        tick();
        chk("sb_setclr_hold", 64'(rs2_busy), 64'(SB));

        // x0 is never busy, even when allocated
        alloc_valid = 1'b1;
        alloc_rd    = 5'd0;
        ReadReg1    = 5'd0;
        tick();
        alloc_valid = 1'b0;
        chk("sb_x0_alloc", 64'(rs1_busy), 64'd0);

        // x0 drop: accepted, no RegWrite, scoreboard untouched (pointer is at 0)
        req_valid = 3'b010;
        set_req(REQ_LSU, 5'd0, 64'h55);
        #1;
        chk("x0_ready", 64'(req_ready), 64'b010);
        tick();
        req_valid = 3'b000;
        chk("x0_regwrite", 64'(RegWrite), 64'd0);
        chk("x0_rs2_busy", 64'(rs2_busy), 64'(SB));

        // pointer now at 2: requesters 0 and 1 valid, search wraps to 0
        req_valid = 3'b011;
        set_req(REQ_ALU, 5'd9, 64'h99);
        #1;
        chk("wrap_ready", 64'(req_ready), 64'b001);
        tick();
        req_valid = 3'b000;
        chk("wrap_writereg", 64'(WriteReg), 64'd9);

        // reset asserted while a transfer is being accepted
        req_valid = 3'b010;
        set_req(REQ_LSU, 5'd4, 64'h44);
        alloc_valid = 1'b1;
        alloc_rd    = 5'd4;
        ReadReg1    = 5'd4;
        #1;
        chk("mid_ready", 64'(req_ready), 64'b010);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", 64'(req_ready), 64'd0);
        chk("mid_rst_rs2", 64'(rs2_busy), 64'd0);
        tick();
        req_valid   = 3'b000;
        alloc_valid = 1'b0;
        chk("mid_rst_regwrite", 64'(RegWrite), 64'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_regwrite", 64'(RegWrite), 64'd0);
        chk("post_rst_rs1", 64'(rs1_busy), 64'd0);
        req_valid = 3'b111;
        #1;
        chk("post_rst_ready", 64'(req_ready), 64'b001);
        req_valid = 3'b000;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have a parameter XLEN, default 64: the writeback data width.
REQ-002 The block SHALL have a parameter NUM_REQ, default 3: the requester count (0 = ALU, 1 = load unit, 2 = mul/div).
REQ-003 The block SHALL have one clock, clk, input, 1 bit, with all state on its rising edge.
REQ-004 The block SHALL have rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have req_valid, input, NUM_REQ bits: per-requester writeback request.
REQ-006 The block SHALL have req_rd, input, NUM_REQ*5 bits: destination register per requester, packed with requester 0 in the LSBs.
REQ-007 The block SHALL have req_data, input, NUM_REQ*XLEN bits: writeback data per requester, packed the same way.
REQ-008 The block SHALL have req_ready, output, NUM_REQ bits: one-hot accept strobe for the current cycle.
REQ-009 The block SHALL have RegWrite, output, 1 bit: register-file write enable.
REQ-010 The block SHALL have WriteReg, output, 5 bits, and WriteData, output, XLEN bits: the register-file write port.
REQ-011 The block SHALL have alloc_valid, input, 1 bit, and alloc_rd, input, 5 bits: destination reservation made at issue.
REQ-012 The block SHALL have ReadReg1 and ReadReg2, inputs, 5 bits each: source registers to check.
REQ-013 The block SHALL have rs1_busy and rs2_busy, outputs, 1 bit each: the source register has a pending write.

Function
REQ-014 Arbitration SHALL be round-robin over the asserted req_valid bits, starting the search at pointer rr_ptr.
REQ-015 At most one req_ready bit SHALL be high per cycle; it SHALL be combinational and asserted only for a requester with req_valid high.
REQ-016 A transfer SHALL occur when req_valid[i] and req_ready[i] are both high; rr_ptr SHALL then become (i+1) mod NUM_REQ; rr_ptr SHALL hold if there is no transfer.
REQ-017 A requester SHALL hold req_valid, req_rd and req_data stable until accepted; the block SHALL NOT require deassertion after acceptance.
REQ-018 A transfer of request i SHALL register RegWrite=1, WriteReg=req_rd[i] and WriteData=req_data[i] on the next edge: 1-cycle latency, one write per cycle, no back-pressure from the register file.
REQ-019 A transfer with rd==0 SHALL be accepted with RegWrite=0 on the following cycle: the x0 write is dropped.
REQ-020 In a cycle with no transfer, RegWrite SHALL be 0 on the next cycle; WriteReg and WriteData SHALL hold their previous values.
REQ-021 With all requesters continuously valid, each requester SHALL be granted exactly once in every NUM_REQ consecutive cycles.

Reset
REQ-022 While rst is high, outputs SHALL be: RegWrite=0, WriteReg=0, WriteData=0, req_ready=0, rs1_busy=0, rs2_busy=0.
REQ-023 While rst is high, internal state SHALL be: rr_ptr=0 and busy vector all zero.
REQ-024 Reset asserted mid-transfer SHALL discard the registered write, so no RegWrite pulse follows reset release.

Configuration
REQ-025 Macro REGFILE_SCOREBOARD_EN SHALL compile in a 32-bit busy vector.
REQ-026 With REGFILE_SCOREBOARD_EN, alloc_valid with alloc_rd!=0 SHALL set busy[alloc_rd] on the next edge.
REQ-027 With REGFILE_SCOREBOARD_EN, a registered write with RegWrite=1 SHALL clear busy[WriteReg] on the next edge.
REQ-028 With REGFILE_SCOREBOARD_EN, a simultaneous set and clear of the same register SHALL leave the bit set; busy[0] SHALL always be 0.
REQ-029 With REGFILE_SCOREBOARD_EN, rsN_busy SHALL equal busy[ReadRegN] combinationally.
REQ-030 Without REGFILE_SCOREBOARD_EN, rs1_busy and rs2_busy SHALL be tied to 0 and alloc_valid/alloc_rd SHALL be ignored; the busy vector SHALL not exist.

Structure
REQ-031 Package regfile_pkg SHALL hold: XLEN, REG_ADDR_W=5, NUM_REGS=32, NUM_REQ, and the requester ID constants (REQ_ALU=0, REQ_LSU=1, REQ_MULDIV=2).
REQ-032 Sub-module rr_arbiter SHALL contain the pointer, the one-hot grant logic and the pointer update, parameterised by NUM_REQ; regfile_wb_arbiter SHALL hold the output register and the scoreboard.

Verification
REQ-033 Single request: req_valid=3'b001, rd=5, data=0xA5 -> req_ready=001 the same cycle; next cycle RegWrite=1, WriteReg=5, WriteData=0xA5.
REQ-034 All valid for 6 cycles from reset -> grants in order 0,1,2,0,1,2; RegWrite=1 on cycles 1 through 6.
REQ-035 x0 drop: requester 1 with rd=0 -> req_ready[1]=1; next cycle RegWrite=0; with the scoreboard, busy unchanged.
REQ-036 Scoreboard: alloc rd=7 at cycle 0 -> rs1_busy=1 for ReadReg1=7 from cycle 1; requester 2 writes rd=7 at cycle 3 -> rs1_busy=0 from cycle 5; alloc of rd=7 on the clearing edge -> stays busy.
REQ-037 Reset mid-operation: rst pulsed while a transfer is accepted -> RegWrite=0 after release, rr_ptr=0, busy=0; the first grant after release goes to requester 0.
